lifo_stack_param: RTL and testbench

//   Parametrised LIFO stack, the successor to the team's fixed 4x8 stack. Adds a count

---
 rtl/lifo_stack_pkg.sv | 18 +
 rtl/lifo_stack_ram.sv | 27 ++
 rtl/lifo_stack_param.sv | 145 ++++++++++++++
 tb/tb_lifo_stack_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_stack_pkg.sv
// Shared definitions for the parametrised LIFO stack.
// Holds the operation encoding and the count-width helper.
package lifo_stack_pkg;

    // Operation encoding is {push, pop}, so a cast of the two strobes decodes it.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } op_e;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int clog2_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_stack_ram.sv
// Storage array for the LIFO stack.
// One synchronous write port, one asynchronous read port, no reset.
module lifo_stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry when enabled; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised LIFO stack with peek, occupancy, almost-full and sticky flags.
// Push and pop in one cycle replace the top (or bypass din when empty).
module lifo_stack_param
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 6
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [WIDTH-1:0]              i_din,
    output logic [WIDTH-1:0]              o_dout,
    output logic                          o_dout_valid,
    output logic [WIDTH-1:0]              o_top,
    output logic [clog2_depth(DEPTH)-1:0] o_count,
    output logic                          o_empty,
    output logic                          o_full,
    output logic                          o_almost_full,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int CW = clog2_depth(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dv;
    logic             r_ovf;
    logic             r_unf;

    logic [CW-1:0]    w_cnt_nx;
    logic [WIDTH-1:0] w_dout_nx;
    logic             w_dv_nx;
    logic             w_ovf_nx;
    logic             w_unf_nx;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic             w_empty;
    logic             w_full;
    op_e              w_op;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == DEPTH_C);
    assign w_op    = op_e'({i_push, i_pop});

    // Top entry sits at count-1; park the read index at 0 while empty.
    assign w_raddr = w_empty ? '0 : AW'(r_cnt - ONE_C);

    lifo_stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_din),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Decode the operation into next count, output word, flags and RAM write.
    always_comb begin
        w_cnt_nx  = r_cnt;
        w_dout_nx = r_dout;
        w_dv_nx   = 1'b0;
        w_ovf_nx  = r_ovf;
        w_unf_nx  = r_unf;
        w_we      = 1'b0;
        w_waddr   = AW'(r_cnt);
        if (i_rst) begin
            w_cnt_nx  = '0;
            w_dout_nx = '0;
            w_ovf_nx  = 1'b0;
            w_unf_nx  = 1'b0;
        end else if (i_clear) begin
            w_cnt_nx = '0;
            w_ovf_nx = 1'b0;
            w_unf_nx = 1'b0;
        end else begin
            unique case (w_op)
                OP_PUSH: begin
                    if (w_full) begin
                        w_ovf_nx = 1'b1;
                    end else begin
                        w_we     = 1'b1;
                        w_cnt_nx = r_cnt + ONE_C;
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        w_unf_nx = 1'b1;
                    end else begin
                        w_dout_nx = w_rdata;
                        w_dv_nx   = 1'b1;
                        w_cnt_nx  = r_cnt - ONE_C;
                    end
                end
                OP_SWAP: begin
                    w_dv_nx = 1'b1;
                    if (w_empty) begin
                        w_dout_nx = i_din;
                    end else begin
                        w_dout_nx = w_rdata;
                        w_we      = 1'b1;
                        w_waddr   = w_raddr;
                    end
                end
                default: begin
                    w_dv_nx = 1'b0;
                end
            endcase
        end
    end

    // Register the control state; reset and clear are folded into next-state.
    always_ff @(posedge i_clk) begin
        r_cnt  <= w_cnt_nx;
        r_dout <= w_dout_nx;
        r_dv   <= w_dv_nx;
        r_ovf  <= w_ovf_nx;
        r_unf  <= w_unf_nx;
    end

    assign o_dout        = r_dout;
    assign o_dout_valid  = r_dv;
    assign o_top         = w_empty ? '0 : w_rdata;
    assign o_count       = r_cnt;
    assign o_empty       = w_empty;
    assign o_full        = w_full;
    assign o_almost_full = (r_cnt >= AFULL_C);
    assign o_overflow    = r_ovf;
    assign o_underflow   = r_unf;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Self-checking bench for lifo_stack_param (WIDTH=8, DEPTH=4, AFULL_LVL=3).
// Directed scenarios followed by random traffic against a queue-based model.
module tb_lifo_stack_param;
    import lifo_stack_pkg::*;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int CW = clog2_depth(D);

    logic          clk;
    logic          rst;
    logic          clear;
    logic          push;
    logic          pop;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic [W-1:0]  top;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic         m_dv;
    logic         m_ovf;
    logic         m_unf;

    lifo_stack_param #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AFULL_LVL (AF)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_clear       (clear),
        .i_push        (push),
        .i_pop         (pop),
        .i_din         (din),
        .o_dout        (dout),
        .o_dout_valid  (dout_valid),
        .o_top         (top),
        .o_count       (count),
        .o_empty       (empty),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_overflow    (overflow),
        .o_underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply behaviour rules to the model for one clock edge.
    task automatic model_step(input logic r, input logic c, input logic pu,
                              input logic po, input logic [W-1:0] d);
        if (r) begin
            q.delete();
            m_dout = '0;
            m_dv = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (c) begin
            q.delete();
            m_dv = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (pu && po) begin
            m_dv = 1'b1;
            if (q.size() > 0) begin
                m_dout = q[q.size()-1];
                q[q.size()-1] = d;
            end else begin
                m_dout = d;
            end
        end else if (pu) begin
            m_dv = 1'b0;
            if (q.size() < D) q.push_back(d);
            else m_ovf = 1'b1;
        end else if (po) begin
            if (q.size() > 0) begin
                m_dout = q.pop_back();
                m_dv = 1'b1;
            end else begin
                m_dv = 1'b0;
                m_unf = 1'b1;
            end
        end else begin
            m_dv = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == D));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".top"}, 32'(top), (n > 0) ? 32'(q[n-1]) : 32'd0);
        chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
        chk({tag, ".dv"}, 32'(dout_valid), 32'(m_dv));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    endtask

    // One clock: drive, step model at the edge, sample 1 time unit later.
    task automatic cyc(input string tag, input logic r, input logic c,
                       input logic pu, input logic po, input logic [W-1:0] d);
        rst = r;
        clear = c;
        push = pu;
        pop = po;
        din = d;
        @(posedge clk);
        model_step(r, c, pu, po, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        din = '0;
        m_dout = '0;
        m_dv = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;

        // Reset state
        cyc("rst0", 1, 0, 0, 0, 8'h00);
        cyc("rst1", 1, 0, 0, 0, 8'h00);
        chk("rst.count", 32'(count), 0);
        chk("rst.top", 32'(top), 0);

        // Fill and drain
        cyc("p11", 0, 0, 1, 0, 8'h11);
        cyc("p22", 0, 0, 1, 0, 8'h22);
        cyc("p33", 0, 0, 1, 0, 8'h33);
        chk("afull3", 32'(almost_full), 1);
        cyc("p44", 0, 0, 1, 0, 8'h44);
        chk("full4", 32'(full), 1);
        chk("top44", 32'(top), 32'h44);

        // Overflow on full
        cyc("ovf", 0, 0, 1, 0, 8'h55);
        chk("ovf.flag", 32'(overflow), 1);
        chk("ovf.top", 32'(top), 32'h44);

        // Swap on full keeps count, no new flag
        cyc("swfull", 0, 0, 1, 1, 8'h66);
        chk("swfull.dout", 32'(dout), 32'h44);
        chk("swfull.top", 32'(top), 32'h66);

        cyc("pop0", 0, 0, 0, 1, 8'h00);
        chk("pop0.dout", 32'(dout), 32'h66);
        cyc("pop1", 0, 0, 0, 1, 8'h00);
        chk("pop1.dout", 32'(dout), 32'h33);
        cyc("pop2", 0, 0, 0, 1, 8'h00);
        cyc("pop3", 0, 0, 0, 1, 8'h00);
        chk("pop3.dout", 32'(dout), 32'h11);

        // Underflow on empty; dout holds
        cyc("unf", 0, 0, 0, 1, 8'h00);
        chk("unf.dout", 32'(dout), 32'h11);
        chk("unf.dv", 32'(dout_valid), 0);
        cyc("clr", 0, 1, 0, 0, 8'h00);
        chk("clr.ovf", 32'(overflow), 0);

        // Replace top on partial stack
        cyc("s11", 0, 0, 1, 0, 8'h11);
        cyc("s22", 0, 0, 1, 0, 8'h22);
        cyc("swap", 0, 0, 1, 1, 8'h99);
        chk("swap.dout", 32'(dout), 32'h22);
        chk("swap.top", 32'(top), 32'h99);
        cyc("idle", 0, 0, 0, 0, 8'h00);

        // Bypass on empty
        cyc("c2", 0, 1, 0, 0, 8'h00);
        cyc("byp", 0, 0, 1, 1, 8'hA5);
        chk("byp.dout", 32'(dout), 32'hA5);
        chk("byp.count", 32'(count), 0);

        // Clear overrides push
        cyc("t1", 0, 0, 1, 0, 8'h01);
        cyc("t2", 0, 0, 1, 0, 8'h02);
        cyc("t3", 0, 0, 1, 0, 8'h03);
        cyc("clrpush", 0, 1, 1, 0, 8'h04);
        chk("clrpush.count", 32'(count), 0);

        // Reset mid-sequence, fresh push lands at the bottom
        cyc("u1", 0, 0, 1, 0, 8'h0A);
        cyc("u2", 0, 0, 1, 0, 8'h0B);
        cyc("rstmid", 1, 0, 1, 0, 8'h0C);
        chk("rstmid.count", 32'(count), 0);
        cyc("fresh", 0, 0, 1, 0, 8'h77);
        chk("fresh.top", 32'(top), 32'h77);
        cyc("freshpop", 0, 0, 0, 1, 8'h00);
        chk("freshpop.dout", 32'(dout), 32'h77);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic r, c, pu, po;
            r  = ($urandom_range(0, 63) == 0);
            c  = ($urandom_range(0, 31) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            cyc("rnd", r, c, pu, po, W'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
